// File: rtl/branch_sequencer.sv
// Multi-cycle fetch/decode/execute/update sequencer for the RISC core.
// Owns the architectural PC and the instruction register and drives the branch unit controls.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_FETCH  | request imem at pc, wait for ack or fetch timeout
// S_DECODE | register brtype / counter_selector from the opcode
// S_EXEC   | pulse alu_start, wait for alu_done, latch flags
// S_UPDATE | load next_pc from the branch unit, link write for JAL
// S_HALT   | HALT opcode or bus error; frozen until reset
module branch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        alu_start,
    input  logic        alu_done,
    input  logic        zero_in,
    input  logic        carry_in,
    input  logic        msb_in,
    input  logic        ovf_in,
    output logic [3:0]  flags,
    output logic [3:0]  brtype,
    output logic [1:0]  counter_selector,
    input  logic [31:0] next_pc,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted,
    output logic        bus_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [7:0] WAIT_LOAD   = 8'(FETCH_TIMEOUT - 1);
    localparam logic [3:0] BR_NEVER    = 4'd9;
    localparam logic [1:0] SEL_REL     = 2'd0;
    localparam logic [1:0] SEL_LABEL   = 2'd1;
    localparam logic [1:0] SEL_REG     = 2'd2;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [3:0]  flags_q, flags_d;
    logic [3:0]  brtype_q, brtype_d;
    logic [1:0]  sel_q, sel_d;
    logic [7:0]  wait_q, wait_d;
    logic        alu_start_q, alu_start_d;
    logic        bus_err_q, bus_err_d;
    logic        run_q;

    logic [5:0]  op;
    logic        is_alu, is_br, is_j, is_jr, is_jal, is_halt;

    assign op      = instr_q[31:26];
    assign is_alu  = (op[5:4] == 2'b00);
    assign is_br   = (op >= 6'h10) && (op <= 6'h18);
    assign is_j    = (op == 6'h20);
    assign is_jr   = (op == 6'h21);
    assign is_jal  = (op == 6'h22);
    assign is_halt = (op == 6'h3F);

    // run_q holds off imem_req for the first cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            flags_q     <= 4'h0;
            brtype_q    <= 4'h0;
            sel_q       <= 2'd0;
            wait_q      <= WAIT_LOAD;
            alu_start_q <= 1'b0;
            bus_err_q   <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            flags_q     <= flags_d;
            brtype_q    <= brtype_d;
            sel_q       <= sel_d;
            wait_q      <= wait_d;
            alu_start_q <= alu_start_d;
            bus_err_q   <= bus_err_d;
            run_q       <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        flags_d     = flags_q;
        brtype_d    = brtype_q;
        sel_d       = sel_q;
        wait_d      = wait_q;
        alu_start_d = 1'b0;
        bus_err_d   = bus_err_q;
        imem_req    = 1'b0;
        link_we     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (run_q) begin
                    imem_req = 1'b1;
                    // An ack on the terminal-count cycle still completes the fetch.
                    if (imem_ack) begin
                        instr_d = imem_rdata;
                        wait_d  = WAIT_LOAD;
                        state_d = S_DECODE;
                    end else if (wait_q == 8'd0) begin
                        bus_err_d = 1'b1;
                        state_d   = S_HALT;
                    end else begin
                        wait_d = wait_q - 8'd1;
                    end
                end
            end
            S_DECODE: begin
                brtype_d = BR_NEVER;
                sel_d    = SEL_REL;
                if (is_br) begin
                    brtype_d = op[3:0];
                end else if (is_j || is_jal) begin
                    sel_d = SEL_LABEL;
                end else if (is_jr) begin
                    sel_d = SEL_REG;
                end
                if (is_alu) begin
                    state_d     = S_EXEC;
                    alu_start_d = 1'b1;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_UPDATE;
                end
            end
            S_EXEC: begin
                if (alu_done) begin
                    flags_d = {ovf_in, msb_in, carry_in, zero_in};
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                pc_d    = next_pc;
                link_we = is_jal;
                wait_d  = WAIT_LOAD;
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign imem_addr        = pc_q;
    assign alu_start        = alu_start_q;
    assign flags            = flags_q;
    assign brtype           = brtype_q;
    assign counter_selector = sel_q;
    assign pc               = pc_q;
    assign instr            = instr_q;
    assign link_data        = pc_q + 32'd1;
    assign halted           = (state_q == S_HALT);
    assign bus_err          = bus_err_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: ALU, branch, J/JAL/JR, fetch timeout, HALT and reset in EXEC.
module tb_branch_sequencer;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        alu_start;
    logic        alu_done;
    logic        zero_in, carry_in, msb_in, ovf_in;
    logic [3:0]  flags;
    logic [3:0]  brtype;
    logic [1:0]  counter_selector;
    logic [31:0] next_pc;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    logic        bus_err;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] OP_ALU1 = 32'h0400_0000;
    localparam logic [31:0] OP_ALU2 = 32'h0800_0000;
    localparam logic [31:0] OP_B1   = 32'h4400_0000;
    localparam logic [31:0] OP_J    = 32'h8000_0000;
    localparam logic [31:0] OP_JR   = 32'h8400_0000;
    localparam logic [31:0] OP_JAL  = 32'h8800_0000;
    localparam logic [31:0] OP_NOP  = 32'hC000_0000;
    localparam logic [31:0] OP_HALT = 32'hFC00_0000;

    branch_sequencer #(
        .RESET_PC      (32'h0000_0100),
        .FETCH_TIMEOUT (4)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ack         (imem_ack),
        .imem_rdata       (imem_rdata),
        .alu_start        (alu_start),
        .alu_done         (alu_done),
        .zero_in          (zero_in),
        .carry_in         (carry_in),
        .msb_in           (msb_in),
        .ovf_in           (ovf_in),
        .flags            (flags),
        .brtype           (brtype),
        .counter_selector (counter_selector),
        .next_pc          (next_pc),
        .pc               (pc),
        .instr            (instr),
        .link_we          (link_we),
        .link_data        (link_data),
        .halted           (halted),
        .bus_err          (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ack(input logic [31:0] word, input logic [31:0] npc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        next_pc    = npc;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {ovf_in, msb_in, carry_in, zero_in} = f;
    endtask

    initial begin
        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = 32'h0; alu_done = 1'b0;
        set_flags(4'h0); next_pc = 32'h0;
        tick(); tick();
        check("rst_pc", pc, 32'h100);
        check("rst_instr", instr, 32'h0);
        check("rst_flags", {28'h0, flags}, 32'h0);
        check("rst_brtype", {28'h0, brtype}, 32'h0);
        check("rst_sel", {30'h0, counter_selector}, 32'h0);
        check("rst_outs", {27'h0, imem_req, alu_start, link_we, halted, bus_err}, 32'h0);
        reset = 1'b0;
        check("req_held_after_rel", {31'h0, imem_req}, 32'h0);

        // ALU op, 0-wait fetch, done on the second EXEC cycle: 5 cycles
        tick();
        check("alu_req", {31'h0, imem_req}, 32'h1);
        check("alu_addr", imem_addr, 32'h100);
        ack(OP_ALU1, 32'h101);
        tick();
        imem_ack = 1'b0;
        alu_done = 1'b1; set_flags(4'hF);
        check("alu_instr", instr, OP_ALU1);
        tick();
        alu_done = 1'b0;
        check("alu_done_ignored_decode", {28'h0, flags}, 32'h0);
        check("alu_start_1st", {31'h0, alu_start}, 32'h1);
        check("alu_brtype", {28'h0, brtype}, 32'h9);
        check("alu_sel", {30'h0, counter_selector}, 32'h0);
        tick();
        check("alu_start_2nd", {31'h0, alu_start}, 32'h0);
        alu_done = 1'b1; set_flags(4'b0101);
        tick();
        alu_done = 1'b0; set_flags(4'h0);
        check("alu_flags", {28'h0, flags}, 32'h5);
        check("alu_upd_req", {30'h0, imem_req, link_we}, 32'h0);
        tick();
        check("alu_pc", pc, 32'h101);
        check("alu_back_fetch", {31'h0, imem_req}, 32'h1);

        // conditional branch op 0x11, stray ack in DECODE must be ignored
        ack(OP_B1, 32'h0F0);
        tick();
        ack(32'hDEAD_BEEF, 32'h0F0);
        tick();
        imem_ack = 1'b0;
        check("br_brtype", {28'h0, brtype}, 32'h1);
        check("br_sel", {30'h0, counter_selector}, 32'h0);
        check("br_no_start", {31'h0, alu_start}, 32'h0);
        check("br_instr_kept", instr, OP_B1);
        check("br_flags_kept", {28'h0, flags}, 32'h5);
        tick();
        check("br_pc", pc, 32'h0F0);

        // J to 0x200
        ack(OP_J, 32'h200);
        tick();
        imem_ack = 1'b0;
        tick();
        check("j_sel", {30'h0, counter_selector}, 32'h1);
        check("j_brtype", {28'h0, brtype}, 32'h9);
        check("j_no_link", {31'h0, link_we}, 32'h0);
        tick();
        check("j_pc", pc, 32'h200);

        // JAL at 0x200
        ack(OP_JAL, 32'h400);
        tick();
        imem_ack = 1'b0;
        tick();
        check("jal_sel", {30'h0, counter_selector}, 32'h1);
        check("jal_link_we", {31'h0, link_we}, 32'h1);
        check("jal_link_data", link_data, 32'h201);
        tick();
        check("jal_pc", pc, 32'h400);
        check("jal_link_pulse_end", {31'h0, link_we}, 32'h0);

        // JR to all-ones
        ack(OP_JR, 32'hFFFF_FFFF);
        tick();
        imem_ack = 1'b0;
        tick();
        check("jr_sel", {30'h0, counter_selector}, 32'h2);
        check("jr_no_link", {31'h0, link_we}, 32'h0);
        tick();
        check("jr_pc", pc, 32'hFFFF_FFFF);

        // JAL at top of address space: link wraps
        ack(OP_JAL, 32'h10);
        tick();
        imem_ack = 1'b0;
        tick();
        check("wrap_link_we", {31'h0, link_we}, 32'h1);
        check("wrap_link_data", link_data, 32'h0);
        tick();
        check("wrap_pc", pc, 32'h10);

        // ack arriving on the 4th wait cycle still fetches
        tick(); tick(); tick();
        check("late_ack_req", {31'h0, imem_req}, 32'h1);
        ack(OP_NOP, 32'h11);
        tick();
        imem_ack = 1'b0;
        check("late_ack_instr", instr, OP_NOP);
        check("late_ack_no_err", {30'h0, halted, bus_err}, 32'h0);
        tick();
        check("nop_brtype", {28'h0, brtype}, 32'h9);
        check("nop_sel", {30'h0, counter_selector}, 32'h0);
        tick();
        check("nop_pc", pc, 32'h11);

        // no ack for 4 cycles: bus error
        tick(); tick(); tick();
        check("to_pre_err", {30'h0, halted, bus_err}, 32'h0);
        tick();
        check("to_bus_err", {31'h0, bus_err}, 32'h1);
        check("to_halted", {31'h0, halted}, 32'h1);
        check("to_req_low", {31'h0, imem_req}, 32'h0);
        check("to_pc_kept", pc, 32'h11);
        ack(OP_ALU1, 32'h55);
        tick(); tick(); tick();
        imem_ack = 1'b0;
        check("to_stays_halted", {29'h0, halted, bus_err, imem_req}, 32'h6);
        check("to_pc_frozen", pc, 32'h11);

        // reset, one ALU op to set flags, then reset inside EXEC
        reset = 1'b1;
        #1;
        check("rst2_pc", pc, 32'h100);
        check("rst2_clear", {30'h0, halted, bus_err}, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        ack(OP_ALU1, 32'h101);
        tick();
        imem_ack = 1'b0;
        tick();
        alu_done = 1'b1; set_flags(4'hF);
        tick();
        alu_done = 1'b0; set_flags(4'h0);
        check("rst2_flags_set", {28'h0, flags}, 32'hF);
        tick();
        check("rst2_pc_upd", pc, 32'h101);
        ack(OP_ALU2, 32'h500);
        tick();
        imem_ack = 1'b0;
        tick();
        check("exec_start", {31'h0, alu_start}, 32'h1);
        reset = 1'b1;
        #1;
        check("exec_rst_pc", pc, 32'h100);
        check("exec_rst_flags", {28'h0, flags}, 32'h0);
        check("exec_rst_outs", {30'h0, alu_start, imem_req}, 32'h0);
        check("exec_rst_brtype", {28'h0, brtype}, 32'h0);
        tick();
        alu_done = 1'b1; set_flags(4'hA);
        reset = 1'b0;
        tick();
        alu_done = 1'b0; set_flags(4'h0);
        check("late_done_flags", {28'h0, flags}, 32'h0);
        check("restart_req", {31'h0, imem_req}, 32'h1);
        check("restart_addr", imem_addr, 32'h100);

        // HALT opcode
        ack(OP_HALT, 32'h777);
        tick();
        imem_ack = 1'b0;
        tick();
        check("halt_halted", {31'h0, halted}, 32'h1);
        check("halt_no_req", {31'h0, imem_req}, 32'h0);
        check("halt_no_err", {31'h0, bus_err}, 32'h0);
        ack(OP_ALU1, 32'h999);
        tick(); tick(); tick();
        imem_ack = 1'b0;
        check("halt_frozen", {30'h0, halted, imem_req}, 32'h2);
        check("halt_pc", pc, 32'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
